input_debounce: RTL and testbench
=================================

# input_debounce

Pin-conditioning stage between the raw input pads (`ui_in[6:1]`) and the GPIO block's `gpio_in` port. Each input bit passes through:

- a two-flop synchronizer,
- a shared sample-tick prescaler,
- a per-bit stability counter.

Each bit produces a clean level plus single-cycle rise/fall strobes, so the GPIO block sees glitch-free levels and edge events for interrupt generation.

## Interface

Parameters:

- `WIDTH`, 6: number of input bits.
- `PRESCALE`, 1000: clk cycles per sample tick; legal range ≥1.
- `STABLE_TICKS`, 4: consecutive differing ticks required to change `o_clean`; legal range ≥1.
- `RESET_LEVEL`, 1'b0: reset value of synchronizer stages and `o_clean` (all bits).

Ports (clock and reset first):

- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `i_raw`, input, WIDTH: asynchronous pad inputs.
- `i_bypass`, input, 1: 1 = `o_clean` follows synchronized input every cycle, no filtering.
- `o_clean`, output, WIDTH: debounced level.
- `o_rise`, output, WIDTH: one-cycle pulse when `o_clean[i]` goes 0→1.
- `o_fall`, output, WIDTH: one-cycle pulse when `o_clean[i]` goes 1→0.

## Operation

Reset state:

- `sync1`, `sync2` and `o_clean` = {WIDTH{RESET_LEVEL}}.
- `o_rise` = `o_fall` = 0.
- Prescaler = 0; all stability counters = 0.

Synchronizer:

- `sync1 <= i_raw`; `sync2 <= sync1`.
- Only `sync2` is used downstream.

Prescaler:

- Counter width = $clog2(PRESCALE) (min 1).
- Counts 0..PRESCALE-1, then wraps to 0.
- `tick` is asserted in the cycle the count equals PRESCALE-1.
- PRESCALE=1: `tick` is asserted every cycle.
- Prescaler runs regardless of `i_bypass`.

Per-bit filter (`i_bypass`=0), evaluated only on `tick`:

- `sync2[i]` == `o_clean[i]`: `cnt[i]` <= 0.
- Differs and `cnt[i]` < STABLE_TICKS-1: `cnt[i]` <= `cnt[i]`+1.
- Differs and `cnt[i]` == STABLE_TICKS-1: `o_clean[i]` <= `sync2[i]`, `cnt[i]` <= 0, and the matching strobe is set.
- Non-tick cycles: counters and `o_clean` hold. Glitches between ticks are invisible.
- A single matching tick anywhere in the run restarts the count from 0.
- `cnt` width = $clog2(STABLE_TICKS+1); never exceeds STABLE_TICKS-1.

Bypass (`i_bypass`=1):

- `o_clean` <= `sync2` every cycle.
- All `cnt` forced to 0.
- Strobes still generated on every change of `o_clean`.
- 1→0 transition: `o_clean` keeps its current value; filtering resumes from `cnt`=0 on the next tick.

Strobes:

- `o_rise[i]` / `o_fall[i]` are registered in the same edge that updates `o_clean[i]`.
- Each is high for exactly one cycle; cleared on the next edge unless `o_clean[i]` changes again. That can happen only in bypass, or with PRESCALE=1 and STABLE_TICKS=1.
- `o_rise[i]` and `o_fall[i]` are never simultaneously high.
- Bits are fully independent: several bits may strobe in the same cycle.

## Timing

- Synchronizer latency: a change on `i_raw` is visible in `sync2` after the 2nd rising edge.
- Filtered latency: `o_clean` changes at the edge of the STABLE_TICKS-th consecutive tick on which `sync2` differs.
  - Worst case ≈ 2 + PRESCALE·STABLE_TICKS cycles.
  - Best case 2 + (STABLE_TICKS-1)·PRESCALE + 1.
- Example, PRESCALE=1, STABLE_TICKS=4, `i_raw[0]` rises before edge 0:
  - `sync2` high after edge 1.
  - Ticks at edges 2, 3, 4, 5.
  - `o_clean[0]`=1 and `o_rise[0]`=1 after edge 5; `o_rise[0]`=0 after edge 6.
- Bypass latency: `o_clean` follows `i_raw` 3 edges later (sync1, sync2, `o_clean`).
- Asynchronous reset assertion mid-count: outputs go to their reset values immediately, without waiting for a clock edge; in-progress counts are discarded.
- After `rst_n` deassertion, the first tick occurs PRESCALE cycles later.

## Test plan

- Reset: RESET_LEVEL=0, `i_raw`=6'h3F held through reset.
  - During reset: `o_clean`=0, strobes 0.
  - After release with PRESCALE=1, STABLE_TICKS=4: `o_clean`=6'h3F after edge 5; `o_rise`=6'h3F for exactly one cycle.
- Glitch rejection: PRESCALE=4, STABLE_TICKS=4, `i_raw[2]` pulses high for 3 cycles between ticks.
  - `o_clean[2]` stays 0; no `o_rise`.
- Bounce restart: PRESCALE=1, STABLE_TICKS=4, `i_raw[1]` pattern 1,1,1,0,1,1,1,1 (one value per cycle).
  - `o_clean[1]` rises only after the final four consecutive 1s reach `sync2`.
  - Exactly one `o_rise[1]` pulse.
- Falling edge and independence: bit 0 falls while bit 5 rises simultaneously, stable.
  - `o_fall[0]` and `o_rise[5]` pulse in the same cycle.
  - All other strobes stay 0.
- Bypass: `i_bypass`=1, toggle `i_raw[3]` every cycle.
  - `o_clean[3]` mirrors `i_raw[3]` delayed 3 cycles, with alternating rise/fall pulses.
  - Set `i_bypass`=0 mid-pattern: `o_clean[3]` holds until STABLE_TICKS differing ticks.
- Reset mid-count: assert `rst_n`=0 after 2 of 4 differing ticks.
  - `o_clean` returns to RESET_LEVEL without waiting for a clock edge.
  - After release, a full 4-tick count is required again.

Source files
------------

// File: rtl/input_debounce.sv
// Purpose: pad-input conditioner: 2-flop sync, shared tick prescaler, per-bit stability filter with rise/fall strobes.
// Latency: 2 sync cycles, then STABLE_TICKS differing ticks (bypass: o_clean follows i_raw 3 edges later).
// Backpressure: none; inputs are sampled every cycle and strobes are single-cycle, never held off.
module input_debounce #(
    parameter int   WIDTH        = 6,
    parameter int   PRESCALE     = 1000,
    parameter int   STABLE_TICKS = 4,
    parameter logic RESET_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_raw,
    input  logic             i_bypass,
    output logic [WIDTH-1:0] o_clean,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    // PRESCALE=1 still needs a one-bit counter; it simply never leaves 0.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [PW-1:0]    r_presc;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    logic             w_tick;
    logic [WIDTH-1:0] w_clean_nxt;
    logic [CW-1:0]    w_cnt_nxt [WIDTH];

    assign w_tick  = (r_presc == PS_LAST);
    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

    // Two-flop synchronizer; only the second stage feeds the filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= {WIDTH{RESET_LEVEL}};
            r_sync2 <= {WIDTH{RESET_LEVEL}};
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Shared prescaler: free-running 0..PRESCALE-1, tick on the last count, independent of bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Per-bit filter: a bit flips only after STABLE_TICKS consecutive ticks that disagree with o_clean.
    always_comb begin
        w_clean_nxt = r_clean;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (i_bypass) begin
                w_clean_nxt[i] = r_sync2[i];
                w_cnt_nxt[i]   = '0;
            end else if (w_tick) begin
                if (r_sync2[i] == r_clean[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    w_clean_nxt[i] = r_sync2[i];
                    w_cnt_nxt[i]   = '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Level, counters and edge strobes all update on the same edge, so strobes line up with o_clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clean <= {WIDTH{RESET_LEVEL}};
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_clean <= w_clean_nxt;
            r_rise  <= w_clean_nxt & ~r_clean;
            r_fall  <= ~w_clean_nxt & r_clean;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
`timescale 1ns/1ps
module tb_input_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] i_raw = 6'h00;
    logic       i_bypass = 1'b0;
    logic [5:0] c1, r1, f1;   // PRESCALE=1 instance
    logic [5:0] c4, r4, f4;   // PRESCALE=4 instance

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    input_debounce #(.WIDTH(6), .PRESCALE(1), .STABLE_TICKS(4), .RESET_LEVEL(1'b0)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .i_raw(i_raw), .i_bypass(i_bypass),
        .o_clean(c1), .o_rise(r1), .o_fall(f1));

    input_debounce #(.WIDTH(6), .PRESCALE(4), .STABLE_TICKS(4), .RESET_LEVEL(1'b0)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .i_raw(i_raw), .i_bypass(i_bypass),
        .o_clean(c4), .o_rise(r4), .o_fall(f4));

    // Reference model. Index 0 = PRESCALE 1, index 1 = PRESCALE 4.
    // A bit flips when the last 4 tick samples taken since its previous change all disagree with it.
    logic [5:0] m_s1, m_s2;
    logic [5:0] m_c [2];
    logic [5:0] m_r [2];
    logic [5:0] m_f [2];
    logic [7:0] m_h [2][6];
    int         m_n [2][6];
    int         m_edges;

    task automatic model_reset();
        m_s1 = 6'h00;
        m_s2 = 6'h00;
        m_edges = 0;
        for (int j = 0; j < 2; j++) begin
            m_c[j] = 6'h00;
            m_r[j] = 6'h00;
            m_f[j] = 6'h00;
            for (int b = 0; b < 6; b++) begin
                m_h[j][b] = 8'h00;
                m_n[j][b] = 0;
            end
        end
    endtask

    task automatic model_edge();
        logic [5:0] nc;
        bit         tk;
        m_edges++;
        for (int j = 0; j < 2; j++) begin
            nc = m_c[j];
            tk = (m_edges % ((j == 0) ? 1 : 4)) == 0;
            for (int b = 0; b < 6; b++) begin
                if (i_bypass) begin
                    nc[b] = m_s2[b];
                    m_n[j][b] = 0;
                end else if (tk) begin
                    m_h[j][b] = {m_h[j][b][6:0], m_s2[b]};
                    m_n[j][b]++;
                    if (m_n[j][b] >= 4 && m_h[j][b][3:0] == {4{~m_c[j][b]}}) begin
                        nc[b] = m_s2[b];
                        m_n[j][b] = 0;
                    end
                end
            end
            m_r[j] = nc & ~m_c[j];
            m_f[j] = ~nc & m_c[j];
            m_c[j] = nc;
        end
        m_s2 = m_s1;
        m_s1 = i_raw;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_edge();
    end

    task automatic test_reset();
        i_raw = 6'h3F;
        i_bypass = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({c1, r1, f1, c4, r4, f4} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got clean/rise/fall p1=%h/%h/%h p4=%h/%h/%h, want all 0", c1, r1, f1, c4, r4, f4);
        end
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            n_checks++;
            if (c1 !== ((e >= 5) ? 6'h3F : 6'h00)) begin
                n_fail++;
                $display("FAIL reset_release_clean edge %0d: got %h want %h", e, c1, (e >= 5) ? 6'h3F : 6'h00);
            end
            n_checks++;
            if (r1 !== ((e == 5) ? 6'h3F : 6'h00)) begin
                n_fail++;
                $display("FAIL reset_release_rise edge %0d: got %h want %h", e, r1, (e == 5) ? 6'h3F : 6'h00);
            end
            n_checks++;
            if ({c1, r1, f1, c4, r4, f4} !== {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]}) begin
                n_fail++;
                $display("FAIL model_reset edge %0d: got %h want %h", e, {c1, r1, f1, c4, r4, f4},
                         {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]});
            end
        end
    endtask

    task automatic test_glitch();
        i_raw = 6'h00;
        repeat (30) @(negedge clk);
        // Place the 3-cycle pulse so it is sampled on no PRESCALE=4 tick.
        for (int k = 0; k < 4 && (m_edges % 4) != 2; k++) @(negedge clk);
        for (int e = 0; e < 24; e++) begin
            if (e == 0) i_raw[2] = 1'b1;
            if (e == 3) i_raw[2] = 1'b0;
            @(negedge clk);
            n_checks++;
            if (c4[2] !== 1'b0 || r4 !== 6'h00 || c1[2] !== 1'b0 || r1 !== 6'h00) begin
                n_fail++;
                $display("FAIL glitch cycle %0d: got p4 clean2=%b rise=%h p1 clean2=%b rise=%h, want 0", e, c4[2], r4, c1[2], r1);
            end
            n_checks++;
            if ({c1, r1, f1, c4, r4, f4} !== {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]}) begin
                n_fail++;
                $display("FAIL model_glitch cycle %0d: got %h want %h", e, {c1, r1, f1, c4, r4, f4},
                         {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]});
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        int         rises;
        int         rise_edge;
        pat = 8'b1111_0111;   // bit k is the value before edge k: 1,1,1,0,1,1,1,1
        rises = 0;
        rise_edge = -1;
        i_raw[1] = pat[0];
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if (r1[1]) begin
                rises++;
                rise_edge = e;
            end
            n_checks++;
            if ({c1, r1, f1, c4, r4, f4} !== {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]}) begin
                n_fail++;
                $display("FAIL model_bounce edge %0d: got %h want %h", e, {c1, r1, f1, c4, r4, f4},
                         {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]});
            end
            i_raw[1] = (e + 1 < 8) ? pat[e + 1] : 1'b1;
        end
        n_checks++;
        if (rises != 1 || rise_edge != 9) begin
            n_fail++;
            $display("FAIL bounce_rise: got %0d pulses at edge %0d, want 1 pulse at edge 9", rises, rise_edge);
        end
        n_checks++;
        if (c1[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_level: got %b want 1", c1[1]);
        end
    endtask

    task automatic test_fall_indep();
        int p1_pulses;
        int p4_pulses;
        p1_pulses = 0;
        p4_pulses = 0;
        i_raw = 6'b000011;
        repeat (30) @(negedge clk);
        i_raw = 6'b100010;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            if ((r1 | f1) != 6'h00) begin
                p1_pulses++;
                n_checks++;
                if (r1 !== 6'h20 || f1 !== 6'h01) begin
                    n_fail++;
                    $display("FAIL indep_p1 edge %0d: got rise=%h fall=%h want rise=20 fall=01", e, r1, f1);
                end
            end
            if ((r4 | f4) != 6'h00) begin
                p4_pulses++;
                n_checks++;
                if (r4 !== 6'h20 || f4 !== 6'h01) begin
                    n_fail++;
                    $display("FAIL indep_p4 edge %0d: got rise=%h fall=%h want rise=20 fall=01", e, r4, f4);
                end
            end
            n_checks++;
            if ({c1, r1, f1, c4, r4, f4} !== {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]}) begin
                n_fail++;
                $display("FAIL model_indep edge %0d: got %h want %h", e, {c1, r1, f1, c4, r4, f4},
                         {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]});
            end
        end
        n_checks++;
        if (p1_pulses != 1 || p4_pulses != 1 || c1 !== 6'b100010 || c4 !== 6'b100010) begin
            n_fail++;
            $display("FAIL indep_count: got p1 %0d p4 %0d pulses clean %h/%h, want 1/1 and 22/22", p1_pulses, p4_pulses, c1, c4);
        end
    endtask

    task automatic test_bypass();
        logic v [48];
        for (int k = 0; k < 48; k++) v[k] = (k % 2 == 0);
        i_bypass = 1'b1;
        i_raw[3] = v[0];
        for (int e = 0; e < 26; e++) begin
            @(negedge clk);
            if (e >= 2 && e < 16) begin
                n_checks++;
                if (c1[3] !== v[e - 2] || c4[3] !== v[e - 2]) begin
                    n_fail++;
                    $display("FAIL bypass_follow edge %0d: got %b/%b want %b", e, c1[3], c4[3], v[e - 2]);
                end
            end
            if (e >= 3 && e < 16) begin
                n_checks++;
                if (r1[3] !== v[e - 2] || f1[3] !== !v[e - 2] || r4[3] !== v[e - 2] || f4[3] !== !v[e - 2]) begin
                    n_fail++;
                    $display("FAIL bypass_strobe edge %0d: got r/f p1=%b%b p4=%b%b want %b%b", e, r1[3], f1[3], r4[3], f4[3], v[e - 2], !v[e - 2]);
                end
            end
            if (e >= 16) begin
                n_checks++;
                if (c1[3] !== v[13] || c4[3] !== v[13]) begin
                    n_fail++;
                    $display("FAIL bypass_off_hold edge %0d: got %b/%b want %b", e, c1[3], c4[3], v[13]);
                end
            end
            n_checks++;
            if ({c1, r1, f1, c4, r4, f4} !== {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]}) begin
                n_fail++;
                $display("FAIL model_bypass edge %0d: got %h want %h", e, {c1, r1, f1, c4, r4, f4},
                         {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]});
            end
            i_raw[3] = v[e + 1];
            if (e + 1 == 16) i_bypass = 1'b0;
        end
        i_raw[3] = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            n_checks++;
            if ({c1, r1, f1, c4, r4, f4} !== {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]}) begin
                n_fail++;
                $display("FAIL model_bypass_resume cycle %0d: got %h want %h", e, {c1, r1, f1, c4, r4, f4},
                         {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]});
            end
        end
        n_checks++;
        if (c1[3] !== 1'b1 || c4[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_resume_level: got %b/%b want 1", c1[3], c4[3]);
        end
    endtask

    task automatic test_reset_mid();
        i_raw = 6'b111010;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            n_checks++;
            if (c1 !== 6'b101010) begin
                n_fail++;
                $display("FAIL resetmid_precount edge %0d: got %h want 2a", e, c1);
            end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({c1, r1, f1, c4, r4, f4} !== 36'h0) begin
            n_fail++;
            $display("FAIL resetmid_async: got clean p1=%h p4=%h strobes %h/%h/%h/%h, want all 0", c1, c4, r1, f1, r4, f4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            n_checks++;
            if (c1 !== ((e >= 5) ? 6'h3A : 6'h00) || r1 !== ((e == 5) ? 6'h3A : 6'h00)) begin
                n_fail++;
                $display("FAIL resetmid_recount edge %0d: got clean %h rise %h want %h %h", e, c1, r1,
                         (e >= 5) ? 6'h3A : 6'h00, (e == 5) ? 6'h3A : 6'h00);
            end
            n_checks++;
            if ({c1, r1, f1, c4, r4, f4} !== {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]}) begin
                n_fail++;
                $display("FAIL model_resetmid edge %0d: got %h want %h", e, {c1, r1, f1, c4, r4, f4},
                         {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]});
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 70; s++) begin
            i_raw    = 6'($urandom);
            i_bypass = ($urandom_range(0, 7) == 0);
            hold     = $urandom_range(1, 24);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                n_checks++;
                if ({c1, r1, f1, c4, r4, f4} !== {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]}) begin
                    n_fail++;
                    $display("FAIL model_random seg %0d cycle %0d: got %h want %h", s, c, {c1, r1, f1, c4, r4, f4},
                             {m_c[0], m_r[0], m_f[0], m_c[1], m_r[1], m_f[1]});
                end
            end
        end
        i_bypass = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_bounce();
        test_fall_indep();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
